i2s_sample_bridge: RTL and testbench
====================================

// Module: i2s_sample_bridge
// PURPOSE
//   Parametrised sample path between the I2S RX codec, the per-sample DSP chain and the I2S TX codec.
//   Sequences the codec enable after reset.
//   Demultiplexes the interleaved ADC word stream into channel-tagged SAMPLE_W samples for processing.
//   Buffers the processed samples in per-channel FIFOs and packs them into 32-bit DAC words on each
//   codec request. Overflow, underflow and mute are handled here so the DSP chain never stalls the codec.
// PARAMETERS
//   IN_W        24  codec sample resolution; valid data occupies adc_data_i[IN_W-1:0]
//   SAMPLE_W    16  DSP sample width, signed; must be <= IN_W
//   NUM_CH       2  interleaved channels per frame, >= 1
//   FIFO_DEPTH   4  entries per channel FIFO; must be a power of 2, >= 2
//   EN_DELAY     4  cycles after reset release before conf_en_o rises, >= 1
//   (CH_W = max(1, $clog2(NUM_CH)))
// PORTS
//   lmmi_clk_i     in   1         system clock; the only clock
//   reset          in   1         asynchronous reset, active-high
//   conf_en_o      out  1         codec enable, drives conf_en_i of both codecs
//   adc_valid_i    in   1         RX codec mem_rdwr_o, single-cycle strobe
//   adc_data_i     in   32        RX codec sample_dat_o
//   proc_valid_o   out  1         single-cycle strobe to the DSP chain
//   proc_ch_o      out  CH_W      channel index of proc_data_o
//   proc_data_o    out  SAMPLE_W  signed sample to the DSP chain
//   proc_valid_i   in   1         processed sample strobe from the DSP chain
//   proc_ch_i      in   CH_W      channel index of proc_data_i
//   proc_data_i    in   SAMPLE_W  processed signed sample
//   dac_request_i  in   1         TX codec mem_rdwr_o, single-cycle strobe
//   dac_data_o     out  32        TX codec sample_dat_i
//   mute_i         in   1         1 = force DAC output to zero
//   clear_i        in   1         clears the sticky flags
//   overflow_o     out  1         sticky: a processed sample was dropped
//   underflow_o    out  1         sticky: the DAC request found its channel FIFO empty
// BEHAVIOUR
//   Reset:
//   - All outputs are 0 while reset is high.
//   - FIFOs are emptied, rx_ch = tx_ch = 0, last-sample registers are 0.
//   - Reset takes effect immediately mid-transfer; no partial state survives.
//   Enable:
//   - A counter runs from reset release. conf_en_o goes to 1 at the EN_DELAY-th rising edge and holds.
//   Ingress:
//   - adc_valid_i is ignored while conf_en_o = 0.
//   - On adc_valid_i at edge t, at t+1: proc_data_o = adc_data_i[IN_W-1 -: SAMPLE_W] (MSB-aligned truncation,
//     no rounding), proc_ch_o = rx_ch, proc_valid_o = 1 for that one cycle.
//   - rx_ch then increments and wraps from NUM_CH-1 to 0.
//   - proc_data_o and proc_ch_o hold between strobes.
//   Egress FIFO:
//   - One FIFO per channel, depth FIFO_DEPTH.
//   - proc_valid_i pushes proc_data_i into FIFO[proc_ch_i].
//   - Push while full: the sample is dropped and overflow_o is set.
//   - proc_ch_i >= NUM_CH: the push is ignored and no flag is set.
//   DAC request:
//   - On dac_request_i at edge t, dac_data_o updates at t+1 and holds until the next request.
//   - FIFO[tx_ch] non-empty: pop the head, store it in last[tx_ch], set dac_data_o = pack(head).
//   - FIFO[tx_ch] empty: set underflow_o and dac_data_o = pack(last[tx_ch]) (hold the last sample).
//   - tx_ch increments and wraps after every request, whether or not the pop succeeded.
//   - pack(s) = {(32-IN_W)'b0, s, (IN_W-SAMPLE_W)'b0}; with the defaults this is {8'b0, s, 8'b0}.
//   - mute_i = 1: pops and last[] updates proceed as normal, but dac_data_o = 0.
//   Simultaneous events:
//   - Push and pop on the same FIFO in one cycle: the pop is evaluated first.
//   - A full FIFO therefore accepts the push, with no overflow.
//   - An empty FIFO underflows; there is no fall-through of the pushed sample.
//   - clear_i together with a new error: the set wins and the flag remains 1.
//   - adc_valid_i and dac_request_i in the same cycle are independent; both are serviced.
//   Pointers:
//   - Read/write pointers are log2(FIFO_DEPTH)+1 bits wide with natural wrap.
//   - full = MSB differs and the low bits are equal; empty = pointers equal.
// TESTING
//   1. Reset release, EN_DELAY=4 -> conf_en_o = 1 at the 4th edge. An adc_valid_i pulse before that gives no proc_valid_o.
//   2. adc_data_i 0x00ABCDEF then 0x00123456 -> proc_data_o 0xABCD on ch0, then 0x1234 on ch1, each 1 cycle after its strobe.
//   3. Push 0x7FFF on ch0, then dac_request_i -> dac_data_o = 0x007FFF00 next cycle; the following request (ch1, empty) -> dac_data_o = 0, underflow_o = 1.
//   4. 5 pushes to ch0 with FIFO_DEPTH=4 -> overflow_o = 1; the following pops return pushes 1-4 in order, and the 5th sample is dropped.
//   5. Full ch0 FIFO with push and pop in the same cycle -> no overflow, and the FIFO remains full.
//   6. mute_i = 1 during a request -> dac_data_o = 0 and the FIFO still pops. Assert reset mid-stream -> all outputs are 0 immediately and FIFOs are empty afterwards.

Source files
------------

// File: rtl/i2s_sample_bridge.sv
// i2s_sample_bridge: sample path between I2S RX codec, DSP chain and I2S TX codec.
// Sequences the codec enable, demuxes ADC words into channel-tagged samples,
// buffers processed samples per channel and packs them into DAC words.
//
// Ports:
//   lmmi_clk_i     system clock
//   reset          asynchronous reset, active-high
//   conf_en_o      codec enable, rises EN_DELAY edges after reset release
//   adc_valid_i    ADC word strobe
//   adc_data_i     ADC word, sample in [IN_W-1:0]
//   proc_valid_o   sample strobe to DSP chain
//   proc_ch_o      channel of proc_data_o
//   proc_data_o    MSB-aligned truncated sample to DSP chain
//   proc_valid_i   processed sample strobe
//   proc_ch_i      channel of proc_data_i
//   proc_data_i    processed sample
//   dac_request_i  DAC word request strobe
//   dac_data_o     packed DAC word, held between requests
//   mute_i         forces dac_data_o to zero
//   clear_i        clears sticky flags
//   overflow_o     sticky: processed sample dropped on full FIFO
//   underflow_o    sticky: DAC request found its FIFO empty
module i2s_sample_bridge #(
    parameter int IN_W       = 24,
    parameter int SAMPLE_W   = 16,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int EN_DELAY   = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                lmmi_clk_i,
    input  logic                reset,
    output logic                conf_en_o,
    input  logic                adc_valid_i,
    input  logic [31:0]         adc_data_i,
    output logic                proc_valid_o,
    output logic [CH_W-1:0]     proc_ch_o,
    output logic [SAMPLE_W-1:0] proc_data_o,
    input  logic                proc_valid_i,
    input  logic [CH_W-1:0]     proc_ch_i,
    input  logic [SAMPLE_W-1:0] proc_data_i,
    input  logic                dac_request_i,
    output logic [31:0]         dac_data_o,
    input  logic                mute_i,
    input  logic                clear_i,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int ENW = $clog2(EN_DELAY + 1);

    logic [ENW-1:0]      en_cnt_q, en_cnt_d;
    logic                en_q, en_d;
    logic [CH_W-1:0]     rx_ch_q, rx_ch_d;
    logic [CH_W-1:0]     tx_ch_q, tx_ch_d;
    logic                pv_q, pv_d;
    logic [CH_W-1:0]     pch_q, pch_d;
    logic [SAMPLE_W-1:0] pdat_q, pdat_d;
    logic [31:0]         dac_q, dac_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [PW-1:0]       wptr_q [NUM_CH];
    logic [PW-1:0]       wptr_d [NUM_CH];
    logic [PW-1:0]       rptr_q [NUM_CH];
    logic [PW-1:0]       rptr_d [NUM_CH];
    logic [SAMPLE_W-1:0] mem_q  [NUM_CH][FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_d  [NUM_CH][FIFO_DEPTH];
    logic [SAMPLE_W-1:0] last_q [NUM_CH];
    logic [SAMPLE_W-1:0] last_d [NUM_CH];

    logic [NUM_CH-1:0]   empty;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   pop_sel;
    logic [NUM_CH-1:0]   push_sel;
    logic [SAMPLE_W-1:0] dac_smp;

    function automatic logic [31:0] pack(input logic [SAMPLE_W-1:0] s);
        logic [31:0] r;
        r = '0;
        r[IN_W-1 -: SAMPLE_W] = s;
        return r;
    endfunction

    // Per-channel status and strobe decode. Channel decode by equality
    // means an out-of-range proc_ch_i selects no FIFO at all.
    always_comb begin
        empty    = '0;
        full     = '0;
        pop_sel  = '0;
        push_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c] = (wptr_q[c] == rptr_q[c]);
            full[c]  = (wptr_q[c][AW] != rptr_q[c][AW]) &&
                       (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]);
            pop_sel[c]  = dac_request_i && (tx_ch_q == CH_W'(c)) && !empty[c];
            push_sel[c] = proc_valid_i && (proc_ch_i == CH_W'(c));
        end
    end

    always_comb begin
        en_cnt_d = en_cnt_q;
        en_d     = en_q;
        rx_ch_d  = rx_ch_q;
        tx_ch_d  = tx_ch_q;
        pv_d     = 1'b0;
        pch_d    = pch_q;
        pdat_d   = pdat_q;
        dac_d    = dac_q;
        ovf_d    = clear_i ? 1'b0 : ovf_q;
        unf_d    = clear_i ? 1'b0 : unf_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        mem_d    = mem_q;
        last_d   = last_q;
        dac_smp  = '0;

        if (!en_q) begin
            en_cnt_d = en_cnt_q + ENW'(1);
            en_d     = (en_cnt_q == ENW'(EN_DELAY - 1));
        end

        if (adc_valid_i && en_q) begin
            pv_d    = 1'b1;
            pch_d   = rx_ch_q;
            pdat_d  = adc_data_i[IN_W-1 -: SAMPLE_W];
            rx_ch_d = (rx_ch_q == CH_W'(NUM_CH - 1)) ? '0 : rx_ch_q + CH_W'(1);
        end

        // Pop is evaluated before push: a full FIFO being popped this
        // cycle has room, and an empty one never forwards the push.
        for (int c = 0; c < NUM_CH; c++) begin
            if (pop_sel[c]) begin
                rptr_d[c] = rptr_q[c] + PW'(1);
                last_d[c] = mem_q[c][rptr_q[c][AW-1:0]];
            end
            if (push_sel[c]) begin
                if (full[c] && !pop_sel[c]) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_d[c][wptr_q[c][AW-1:0]] = proc_data_i;
                    wptr_d[c] = wptr_q[c] + PW'(1);
                end
            end
        end

        if (dac_request_i) begin
            if (!empty[tx_ch_q]) begin
                dac_smp = mem_q[tx_ch_q][rptr_q[tx_ch_q][AW-1:0]];
            end else begin
                dac_smp = last_q[tx_ch_q];
                unf_d   = 1'b1;
            end
            dac_d   = mute_i ? 32'd0 : pack(dac_smp);
            tx_ch_d = (tx_ch_q == CH_W'(NUM_CH - 1)) ? '0 : tx_ch_q + CH_W'(1);
        end
    end

    always_ff @(posedge lmmi_clk_i or posedge reset) begin
        if (reset) begin
            en_cnt_q <= '0;
            en_q     <= 1'b0;
            rx_ch_q  <= '0;
            tx_ch_q  <= '0;
            pv_q     <= 1'b0;
            pch_q    <= '0;
            pdat_q   <= '0;
            dac_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                last_q[c] <= '0;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[c][i] <= '0;
                end
            end
        end else begin
            en_cnt_q <= en_cnt_d;
            en_q     <= en_d;
            rx_ch_q  <= rx_ch_d;
            tx_ch_q  <= tx_ch_d;
            pv_q     <= pv_d;
            pch_q    <= pch_d;
            pdat_q   <= pdat_d;
            dac_q    <= dac_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            mem_q    <= mem_d;
            last_q   <= last_d;
        end
    end

    assign conf_en_o    = en_q;
    assign proc_valid_o = pv_q;
    assign proc_ch_o    = pch_q;
    assign proc_data_o  = pdat_q;
    assign dac_data_o   = dac_q;
    assign overflow_o   = ovf_q;
    assign underflow_o  = unf_q;

endmodule

// File: tb/tb_i2s_sample_bridge.sv
// Testbench for i2s_sample_bridge with default parameters.
// Expected DSP and DAC outputs are queued by stimulus and checked by monitors.
module tb_i2s_sample_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        conf_en_o;
    logic        adc_valid_i = 1'b0;
    logic [31:0] adc_data_i = '0;
    logic        proc_valid_o;
    logic [0:0]  proc_ch_o;
    logic [15:0] proc_data_o;
    logic        proc_valid_i = 1'b0;
    logic [0:0]  proc_ch_i = '0;
    logic [15:0] proc_data_i = '0;
    logic        dac_request_i = 1'b0;
    logic [31:0] dac_data_o;
    logic        mute_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        overflow_o;
    logic        underflow_o;

    int n_cmp = 0;
    int n_fail = 0;

    logic [16:0] proc_q[$];
    logic [31:0] dac_q[$];
    logic        req_seen;

    always #5 clk = ~clk;

    i2s_sample_bridge dut (
        .lmmi_clk_i    (clk),
        .reset         (reset),
        .conf_en_o     (conf_en_o),
        .adc_valid_i   (adc_valid_i),
        .adc_data_i    (adc_data_i),
        .proc_valid_o  (proc_valid_o),
        .proc_ch_o     (proc_ch_o),
        .proc_data_o   (proc_data_o),
        .proc_valid_i  (proc_valid_i),
        .proc_ch_i     (proc_ch_i),
        .proc_data_i   (proc_data_i),
        .dac_request_i (dac_request_i),
        .dac_data_o    (dac_data_o),
        .mute_i        (mute_i),
        .clear_i       (clear_i),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Tracks which DAC requests were taken at the previous edge.
    always @(posedge clk or posedge reset) begin
        if (reset) req_seen <= 1'b0;
        else       req_seen <= dac_request_i;
    end

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clk) begin
        if (!reset && proc_valid_o) begin
            if (proc_q.size() == 0) begin
                check("proc_unexpected", {15'd0, proc_ch_o, proc_data_o}, 32'hFFFF_FFFF);
            end else begin
                check("proc_ch_data", {15'd0, proc_ch_o, proc_data_o},
                      {15'd0, proc_q.pop_front()});
            end
        end
        if (!reset && req_seen) begin
            if (dac_q.size() == 0) begin
                check("dac_unexpected", dac_data_o, 32'hFFFF_FFFF);
            end else begin
                check("dac_data", dac_data_o, dac_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adc(input logic [31:0] w, input logic ch, input logic [15:0] exp);
        proc_q.push_back({ch, exp});
        adc_data_i  = w;
        adc_valid_i = 1'b1;
        tick();
        adc_valid_i = 1'b0;
    endtask

    task automatic push(input logic ch, input logic [15:0] d);
        proc_ch_i    = ch;
        proc_data_i  = d;
        proc_valid_i = 1'b1;
        tick();
        proc_valid_i = 1'b0;
    endtask

    task automatic req(input logic [31:0] exp);
        dac_q.push_back(exp);
        dac_request_i = 1'b1;
        tick();
        dac_request_i = 1'b0;
    endtask

    task automatic clear_flags();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("ovf_cleared", {31'd0, overflow_o}, 32'd0);
        check("unf_cleared", {31'd0, underflow_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_conf_en", {31'd0, conf_en_o}, 32'd0);
        check("rst_proc_valid", {31'd0, proc_valid_o}, 32'd0);
        check("rst_dac", dac_data_o, 32'd0);
        check("rst_flags", {30'd0, overflow_o, underflow_o}, 32'd0);

        // Enable delay; ADC strobe before enable is ignored
        reset = 1'b0;
        adc_data_i  = 32'h00FF_FF00;
        adc_valid_i = 1'b1;
        tick();
        adc_valid_i = 1'b0;
        check("en_edge1", {31'd0, conf_en_o}, 32'd0);
        tick();
        tick();
        check("en_edge3", {31'd0, conf_en_o}, 32'd0);
        tick();
        check("en_edge4", {31'd0, conf_en_o}, 32'd1);

        // Ingress demux and truncation
        adc(32'h00AB_CDEF, 1'b0, 16'hABCD);
        adc(32'h0012_3456, 1'b1, 16'h1234);
        tick();
        check("proc_hold", {16'd0, proc_data_o}, 32'h0000_1234);
        adc(32'hFF80_0001, 1'b0, 16'h8000);

        // Pop then underflow on empty ch1
        push(1'b0, 16'h7FFF);
        req(32'h007F_FF00);
        req(32'h0000_0000);
        check("unf_set", {31'd0, underflow_o}, 32'd1);
        check("ovf_clear_t3", {31'd0, overflow_o}, 32'd0);
        clear_flags();

        // Overflow: 5th push to depth-4 FIFO dropped
        push(1'b0, 16'h1111);
        push(1'b0, 16'h2222);
        push(1'b0, 16'h3333);
        push(1'b0, 16'h4444);
        check("ovf_not_yet", {31'd0, overflow_o}, 32'd0);
        push(1'b0, 16'h5555);
        check("ovf_set", {31'd0, overflow_o}, 32'd1);
        req(32'h0011_1100);
        req(32'h0000_0000);
        req(32'h0022_2200);
        req(32'h0000_0000);
        req(32'h0033_3300);
        req(32'h0000_0000);
        req(32'h0044_4400);
        req(32'h0000_0000);
        req(32'h0044_4400);
        req(32'h0000_0000);
        clear_flags();

        // Full FIFO with simultaneous push and pop
        push(1'b0, 16'h0A01);
        push(1'b0, 16'h0A02);
        push(1'b0, 16'h0A03);
        push(1'b0, 16'h0A04);
        dac_q.push_back(32'h000A_0100);
        proc_ch_i     = 1'b0;
        proc_data_i   = 16'h0A05;
        proc_valid_i  = 1'b1;
        dac_request_i = 1'b1;
        tick();
        proc_valid_i  = 1'b0;
        dac_request_i = 1'b0;
        check("simul_no_ovf", {31'd0, overflow_o}, 32'd0);
        push(1'b0, 16'h0A06);
        check("still_full_ovf", {31'd0, overflow_o}, 32'd1);
        clear_flags();

        // Mute still pops
        req(32'h0000_0000);
        mute_i = 1'b1;
        req(32'h0000_0000);
        mute_i = 1'b0;
        req(32'h0000_0000);
        req(32'h000A_0300);
        check("dac_hold", dac_data_o, 32'h000A_0300);

        // Reset mid-stream
        push(1'b1, 16'h1234);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_dac", dac_data_o, 32'd0);
        check("midrst_conf_en", {31'd0, conf_en_o}, 32'd0);
        check("midrst_proc", {15'd0, proc_valid_o, proc_data_o}, 32'd0);
        check("midrst_flags", {30'd0, overflow_o, underflow_o}, 32'd0);
        proc_q.delete();
        dac_q.delete();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("re_en", {31'd0, conf_en_o}, 32'd1);
        adc(32'h0055_6677, 1'b0, 16'h5566);
        req(32'h0000_0000);
        req(32'h0000_0000);
        check("post_rst_unf", {31'd0, underflow_o}, 32'd1);
        push(1'b0, 16'h0101);
        req(32'h0001_0100);

        tick();
        tick();
        check("queues_drained", proc_q.size() + dac_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
